// File: rtl/friction_multi.sv
// friction_multi
//   Applies friction decay to NUM_BALLS balls, with the X and Y axes of each
//   ball handled independently. It sits between the physics/collision engine
//   and the position integrator. When every ball has stopped it holds a
//   settle phase, and then returns to idle.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset (0 = reset)
//   clear        synchronous abort back to IDLE
//   cue_hit      shot start strobe (only honoured in IDLE)
//   any_hit      per-ball collision strobe, reloads that ball's deltas
//   mode         0 = geometric (accumulate |speed|), 1 = linear (accumulate 1)
//   settle_en    advances the settle counter while in SETTLE
//   xspeed       signed X speeds, ball i at [i*SPEED_W +: SPEED_W]
//   yspeed       signed Y speeds, same packing
//   xspeed_fric  friction-adjusted X speeds (combinational from xspeed)
//   yspeed_fric  friction-adjusted Y speeds (combinational from yspeed)
//   stopped      per-ball flag, friction has consumed both axis speeds
//   done_fric    high while in SETTLE
//   fric_state   0 IDLE, 1 ROLLING, 2 SETTLE
module friction_multi #(
  parameter int NUM_BALLS      = 4,
  parameter int SPEED_W        = 11,
  parameter int CNT_W          = 12,
  parameter int MAX_FRIC_COUNT = 200,
  parameter int MAX_FRICTION   = 0,
  parameter int MAX_DONE_COUNT = 50
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         cue_hit,
  input  logic [NUM_BALLS-1:0]         any_hit,
  input  logic                         mode,
  input  logic                         settle_en,
  input  logic [NUM_BALLS*SPEED_W-1:0] xspeed,
  input  logic [NUM_BALLS*SPEED_W-1:0] yspeed,
  output logic [NUM_BALLS*SPEED_W-1:0] xspeed_fric,
  output logic [NUM_BALLS*SPEED_W-1:0] yspeed_fric,
  output logic [NUM_BALLS-1:0]         stopped,
  output logic                         done_fric,
  output logic [1:0]                   fric_state
);

  localparam int NCH   = 2 * NUM_BALLS;
  localparam int MAG_W = SPEED_W - 1;
  localparam int SC_W  = (MAX_DONE_COUNT > 0) ? $clog2(MAX_DONE_COUNT + 1) : 1;

  localparam logic [MAG_W-1:0] MAG_MAX = '1;
  localparam logic [MAG_W-1:0] FAB_MAX = (MAX_FRICTION != 0) ? MAG_W'(MAX_FRICTION) : MAG_MAX;
  localparam logic [CNT_W-1:0] FRIC_TH = CNT_W'(MAX_FRIC_COUNT);
  localparam logic [SC_W-1:0]  DONE_TH = SC_W'(MAX_DONE_COUNT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ROLLING = 2'd1;
  localparam logic [1:0] S_SETTLE  = 2'd2;

  logic [1:0]      state;
  logic [SC_W-1:0] settle_cnt;
  logic [NCH-1:0]  ch_stop;
  logic            all_stopped;
  logic            settle_exit;

  // Magnitude of a signed speed. The most-negative code has no positive
  // counterpart, so it is clamped to the largest representable magnitude.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [SPEED_W-1:0] v);
    logic [SPEED_W-1:0] neg;
    neg = -v;
    if (v == {1'b1, {MAG_W{1'b0}}})
      return MAG_MAX;
    else if (v[SPEED_W-1])
      return neg[MAG_W-1:0];
    else
      return v[MAG_W-1:0];
  endfunction

  assign all_stopped = &stopped;
  assign settle_exit = (state == S_SETTLE) && settle_en && (settle_cnt == DONE_TH);
  assign done_fric   = (state == S_SETTLE);
  assign fric_state  = state;

  // Shot sequencing: IDLE waits for a cue strike, ROLLING lasts until every
  // ball has stopped, and SETTLE counts enabled cycles before going back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
    end else if (clear) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          settle_cnt <= '0;
          if (cue_hit)
            state <= S_ROLLING;
        end
        S_ROLLING: begin
          if (all_stopped)
            state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_exit) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
          end else if (settle_en) begin
            settle_cnt <= settle_cnt + SC_W'(1);
          end
        end
        default: begin
          state      <= S_IDLE;
          settle_cnt <= '0;
        end
      endcase
    end
  end

  // Channels 0..NUM_BALLS-1 are the X axes and the remaining channels are the
  // Y axes, so ball b owns channels b and b+NUM_BALLS.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam int BALL = g % NUM_BALLS;

    logic [SPEED_W-1:0] v;
    logic [SPEED_W-1:0] v_out;
    logic [MAG_W-1:0]   mag;
    logic [CNT_W-1:0]   acc;
    logic [MAG_W-1:0]   delta;
    logic [MAG_W-1:0]   fab;
    logic [CNT_W:0]     acc_sum;
    logic [CNT_W-1:0]   acc_next;
    logic [MAG_W-1:0]   fab_inc;
    logic [SPEED_W-1:0] fab_ext;

    if (g < NUM_BALLS) begin : g_x
      assign v = xspeed[BALL*SPEED_W +: SPEED_W];
      assign xspeed_fric[BALL*SPEED_W +: SPEED_W] = v_out;
    end else begin : g_y
      assign v = yspeed[BALL*SPEED_W +: SPEED_W];
      assign yspeed_fric[BALL*SPEED_W +: SPEED_W] = v_out;
    end

    assign mag        = abs_mag(v);
    assign ch_stop[g] = (fab >= mag);
    assign fab_ext    = {1'b0, fab};

    // The extra top bit of the sum detects overflow so that the accumulator
    // saturates instead of wrapping back below the threshold.
    assign acc_sum  = {1'b0, acc} + (mode ? (CNT_W+1)'(1) : (CNT_W+1)'(delta));
    assign acc_next = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
    assign fab_inc  = (fab >= FAB_MAX) ? fab : fab + MAG_W'(1);

    // The magnitude shrinks toward zero while the sign is kept. Once friction
    // has eaten the whole speed, or the shot is settling, the output is zero.
    always_comb begin
      v_out = '0;
      if (!(done_fric || ch_stop[g]))
        v_out = v[SPEED_W-1] ? (v + fab_ext) : (v - fab_ext);
    end

    // Friction update for this channel. A collision restarts the accumulator
    // with the new speed magnitude. Reaching the threshold adds one unit of
    // friction. Every other cycle accumulates. The clear on leaving SETTLE
    // makes sure IDLE passes the speeds through starting from its first cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc   <= '0;
        delta <= '0;
        fab   <= '0;
      end else if (clear) begin
        acc   <= '0;
        delta <= '0;
        fab   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            acc   <= '0;
            fab   <= '0;
            delta <= cue_hit ? mag : '0;
          end
          S_ROLLING: begin
            if (any_hit[BALL]) begin
              acc   <= '0;
              delta <= mag;
            end else if (acc >= FRIC_TH) begin
              acc <= '0;
              fab <= fab_inc;
            end else begin
              acc <= acc_next;
            end
          end
          S_SETTLE: begin
            if (settle_exit) begin
              acc   <= '0;
              delta <= '0;
              fab   <= '0;
            end
          end
          default: begin
            acc   <= '0;
            delta <= '0;
            fab   <= '0;
          end
        endcase
      end
    end
  end

  for (genvar b = 0; b < NUM_BALLS; b++) begin : g_stop
    assign stopped[b] = ch_stop[b] & ch_stop[b + NUM_BALLS];
  end

endmodule

// File: tb/tb_friction_multi.sv
// tb_friction_multi
//   Testbench for friction_multi. It checks the DUT against a reference model
//   that works per shot. For each channel the model tracks how many cycles
//   have passed since the last friction step, and it steps friction once per
//   period. The period is ceil(MAX_FRIC_COUNT / step) + 1 cycles.
module tb_friction_multi;

  localparam int N    = 4;
  localparam int SW   = 11;
  localparam int TH   = 200;
  localparam int DONE = 50;
  localparam int CAP  = 1023;

  logic            clk;
  logic            reset;
  logic            clear;
  logic            cue_hit;
  logic [N-1:0]    any_hit;
  logic            mode;
  logic            settle_en;
  logic [N*SW-1:0] xspeed;
  logic [N*SW-1:0] yspeed;
  logic [N*SW-1:0] xspeed_fric;
  logic [N*SW-1:0] yspeed_fric;
  logic [N-1:0]    stopped;
  logic            done_fric;
  logic [1:0]      fric_state;

  int n_compared;
  int n_mismatched;

  int m_state;
  int m_cnt;
  int m_fab   [2*N];
  int m_delta [2*N];
  int m_phase [2*N];
  int vin     [2*N];

  friction_multi #(
    .NUM_BALLS(N), .SPEED_W(SW), .CNT_W(12), .MAX_FRIC_COUNT(TH),
    .MAX_FRICTION(0), .MAX_DONE_COUNT(DONE)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .cue_hit(cue_hit),
    .any_hit(any_hit), .mode(mode), .settle_en(settle_en),
    .xspeed(xspeed), .yspeed(yspeed),
    .xspeed_fric(xspeed_fric), .yspeed_fric(yspeed_fric),
    .stopped(stopped), .done_fric(done_fric), .fric_state(fric_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mag_of(input int v);
    if (v < -CAP) return CAP;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int exp_ch(input int ch);
    if (m_state == 2 || m_fab[ch] >= mag_of(vin[ch])) return 0;
    return (vin[ch] < 0) ? vin[ch] + m_fab[ch] : vin[ch] - m_fab[ch];
  endfunction

  function automatic logic [N*SW-1:0] exp_bus(input bit axis_y);
    logic [N*SW-1:0] bus;
    logic [SW-1:0]   t;
    bus = '0;
    for (int b = 0; b < N; b++) begin
      t = SW'(exp_ch(axis_y ? b + N : b));
      bus[b*SW +: SW] = t;
    end
    return bus;
  endfunction

  function automatic logic [N-1:0] exp_stop();
    logic [N-1:0] s;
    for (int b = 0; b < N; b++)
      s[b] = (m_fab[b] >= mag_of(vin[b])) && (m_fab[b+N] >= mag_of(vin[b+N]));
    return s;
  endfunction

  task automatic drive_speeds();
    logic [SW-1:0] t;
    for (int b = 0; b < N; b++) begin
      t = SW'(vin[b]);
      xspeed[b*SW +: SW] = t;
      t = SW'(vin[b+N]);
      yspeed[b*SW +: SW] = t;
    end
  endtask

  task automatic zero_speeds();
    for (int c = 0; c < 2*N; c++) vin[c] = 0;
    drive_speeds();
  endtask

  task automatic model_clear();
    m_state = 0;
    m_cnt   = 0;
    for (int c = 0; c < 2*N; c++) begin
      m_fab[c] = 0; m_delta[c] = 0; m_phase[c] = 0;
    end
  endtask

  // Moves the reference model forward by one clock edge, using the inputs
  // as they were just before that edge.
  task automatic model_step();
    bit all_st;
    int stp;
    int n;
    all_st = &exp_stop();
    if (!reset || clear) begin
      model_clear();
    end else if (m_state == 0) begin
      for (int c = 0; c < 2*N; c++) begin
        m_fab[c] = 0; m_phase[c] = 0;
        m_delta[c] = cue_hit ? mag_of(vin[c]) : 0;
      end
      if (cue_hit) m_state = 1;
    end else if (m_state == 1) begin
      for (int c = 0; c < 2*N; c++) begin
        if (any_hit[c % N]) begin
          m_phase[c] = 0;
          m_delta[c] = mag_of(vin[c]);
        end else begin
          stp = mode ? 1 : m_delta[c];
          if (stp > 0) begin
            n = (TH + stp - 1) / stp;
            if (m_phase[c] >= n) begin
              m_phase[c] = 0;
              if (m_fab[c] < CAP) m_fab[c]++;
            end else begin
              m_phase[c]++;
            end
          end
        end
      end
      if (all_st) m_state = 2;
    end else begin
      if (settle_en) begin
        if (m_cnt == DONE) model_clear();
        else m_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic go_idle();
    clear = 1'b1; cue_hit = 1'b0; any_hit = '0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    for (int c = 0; c < 2*N; c++) vin[c] = $urandom_range(0, 400) - 200;
    drive_speeds();
    #1;
    n_compared++;
    if (fric_state !== 2'd0 || done_fric !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: state=%0d done=%0b, required 0/0", fric_state, done_fric);
    end
    n_compared++;
    if (xspeed_fric !== xspeed || yspeed_fric !== yspeed) begin
      n_mismatched++;
      $display("[TB] FAIL reset_passthru: x=%h y=%h, required x=%h y=%h", xspeed_fric, yspeed_fric, xspeed, yspeed);
    end
    tick();
    reset = 1'b1;
    tick();
    n_compared++;
    if (fric_state !== 2'd0 || stopped !== exp_stop()) begin
      n_mismatched++;
      $display("[TB] FAIL reset_release: state=%0d stopped=%b, required 0/%b", fric_state, stopped, exp_stop());
    end
  endtask

  task automatic test_clear_idle();
    zero_speeds();
    vin[0] = 50; drive_speeds();
    clear = 1'b1; cue_hit = 1'b1;
    tick();
    clear = 1'b0; cue_hit = 1'b0;
    n_compared++;
    if (fric_state !== 2'd0 || xspeed_fric !== xspeed) begin
      n_mismatched++;
      $display("[TB] FAIL clear_over_cue: state=%0d x=%h, required 0/%h", fric_state, xspeed_fric, xspeed);
    end
  endtask

  task automatic test_geometric();
    logic [SW-1:0] ev;
    zero_speeds();
    vin[0] = 100; drive_speeds();
    mode = 1'b0; settle_en = 1'b0;
    cue_hit = 1'b1; tick(); cue_hit = 1'b0;
    for (int e = 1; e <= 300; e++) begin
      tick();
      ev = SW'(100 - e / 3);
      n_compared++;
      if (xspeed_fric[SW-1:0] !== ev || stopped[0] !== (e == 300) || fric_state !== 2'd1) begin
        n_mismatched++;
        $display("[TB] FAIL geo_decay e=%0d: out=%0d stop=%b st=%0d, required %0d/%b/1",
                 e, $signed(xspeed_fric[SW-1:0]), stopped[0], fric_state, $signed(ev), (e == 300));
      end
    end
    tick();
    n_compared++;
    if (fric_state !== 2'd2 || done_fric !== 1'b1 || xspeed_fric !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL geo_settle: state=%0d done=%0b x=%h, required 2/1/0", fric_state, done_fric, xspeed_fric);
    end
    go_idle();
  endtask

  task automatic test_linear();
    logic [SW-1:0] ev;
    int f;
    zero_speeds();
    vin[0] = -5; drive_speeds();
    mode = 1'b1;
    cue_hit = 1'b1; tick(); cue_hit = 1'b0;
    for (int e = 1; e <= 1005; e++) begin
      tick();
      f  = e / 201;
      ev = (f >= 5) ? '0 : SW'(-5 + f);
      n_compared++;
      if (xspeed_fric[SW-1:0] !== ev || stopped[0] !== (e >= 1005)) begin
        n_mismatched++;
        $display("[TB] FAIL lin_decay e=%0d: out=%0d stop=%b, required %0d/%b",
                 e, $signed(xspeed_fric[SW-1:0]), stopped[0], $signed(ev), (e >= 1005));
      end
    end
    tick();
    n_compared++;
    if (fric_state !== 2'd2) begin
      n_mismatched++;
      $display("[TB] FAIL lin_settle: state=%0d, required 2", fric_state);
    end
    mode = 1'b0;
    go_idle();
  endtask

  task automatic test_hit();
    logic [SW-1:0] ev;
    zero_speeds();
    vin[0] = 100; drive_speeds();
    mode = 1'b0;
    cue_hit = 1'b1; tick(); cue_hit = 1'b0;
    for (int e = 1; e <= 30; e++) tick();
    n_compared++;
    if (xspeed_fric[SW-1:0] !== SW'(90)) begin
      n_mismatched++;
      $display("[TB] FAIL hit_pre: out=%0d, required 90", $signed(xspeed_fric[SW-1:0]));
    end
    vin[0] = -40; drive_speeds();
    any_hit = 4'b0001;
    #1;
    ev = SW'(-30);
    n_compared++;
    if (xspeed_fric[SW-1:0] !== ev) begin
      n_mismatched++;
      $display("[TB] FAIL hit_now: out=%0d, required -30", $signed(xspeed_fric[SW-1:0]));
    end
    tick();
    any_hit = '0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      ev = (k < 6) ? SW'(-30) : SW'(-29);
      n_compared++;
      if (xspeed_fric[SW-1:0] !== ev) begin
        n_mismatched++;
        $display("[TB] FAIL hit_period k=%0d: out=%0d, required %0d", k, $signed(xspeed_fric[SW-1:0]), $signed(ev));
      end
    end
    go_idle();
  endtask

  task automatic test_zero_settle();
    zero_speeds();
    settle_en = 1'b1;
    cue_hit = 1'b1; tick(); cue_hit = 1'b0;
    n_compared++;
    if (fric_state !== 2'd1) begin
      n_mismatched++;
      $display("[TB] FAIL zero_roll: state=%0d, required 1", fric_state);
    end
    tick();
    for (int k = 1; k <= 51; k++) begin
      n_compared++;
      if (fric_state !== 2'd2 || done_fric !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL zero_settle k=%0d: state=%0d done=%0b, required 2/1", k, fric_state, done_fric);
      end
      tick();
    end
    n_compared++;
    if (fric_state !== 2'd0 || done_fric !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL settle_exit: state=%0d done=%0b, required 0/0", fric_state, done_fric);
    end
    settle_en = 1'b0;
    cue_hit = 1'b1; tick(); cue_hit = 1'b0;
    tick();
    for (int k = 0; k < 60; k++) tick();
    cue_hit = 1'b1; tick(); cue_hit = 1'b0;
    n_compared++;
    if (fric_state !== 2'd2) begin
      n_mismatched++;
      $display("[TB] FAIL settle_hold: state=%0d, required 2", fric_state);
    end
    go_idle();
    n_compared++;
    if (fric_state !== 2'd0) begin
      n_mismatched++;
      $display("[TB] FAIL settle_clear: state=%0d, required 0", fric_state);
    end
    settle_en = 1'b1;
  endtask

  task automatic test_saturate();
    logic [SW-1:0] ev;
    zero_speeds();
    vin[0] = -1024; drive_speeds();
    mode = 1'b0;
    cue_hit = 1'b1; tick(); cue_hit = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      ev = SW'(-1024 + e / 2);
      n_compared++;
      if (xspeed_fric[SW-1:0] !== ev || stopped[0] !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL most_neg e=%0d: out=%0d stop=%b, required %0d/0",
                 e, $signed(xspeed_fric[SW-1:0]), stopped[0], $signed(ev));
      end
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    zero_speeds();
    vin[0] = 100; vin[N] = -7; drive_speeds();
    cue_hit = 1'b1; tick(); cue_hit = 1'b0;
    for (int e = 1; e <= 15; e++) tick();
    n_compared++;
    if (xspeed_fric[SW-1:0] !== SW'(95)) begin
      n_mismatched++;
      $display("[TB] FAIL areset_pre: out=%0d, required 95", $signed(xspeed_fric[SW-1:0]));
    end
    reset = 1'b0;
    model_clear();
    #1;
    n_compared++;
    if (xspeed_fric !== xspeed || yspeed_fric !== yspeed || fric_state !== 2'd0 || done_fric !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL areset_now: x=%h y=%h st=%0d done=%0b, required %h/%h/0/0",
               xspeed_fric, yspeed_fric, fric_state, done_fric, xspeed, yspeed);
    end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_compared++;
      if (fric_state !== 2'd0 || xspeed_fric !== xspeed || yspeed_fric !== yspeed) begin
        n_mismatched++;
        $display("[TB] FAIL areset_quiet k=%0d: st=%0d x=%h, required 0/%h", k, fric_state, xspeed_fric, xspeed);
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    int b;
    for (int shot = 0; shot < 6; shot++) begin
      mode = shot[0];
      for (int c = 0; c < 2*N; c++)
        vin[c] = mode ? $urandom_range(0, 10) - 5 : $urandom_range(0, 600) - 300;
      drive_speeds();
      cue_hit = 1'b1; tick(); cue_hit = 1'b0;
      cyc = 0;
      while (m_state != 0 && cyc < 3000) begin
        settle_en = $urandom_range(0, 1);
        if (m_state == 1 && cyc < 100 && $urandom_range(0, 39) == 0) begin
          b = $urandom_range(0, N-1);
          vin[b]   = mode ? $urandom_range(0, 10) - 5 : $urandom_range(0, 600) - 300;
          vin[b+N] = mode ? $urandom_range(0, 10) - 5 : $urandom_range(0, 600) - 300;
          drive_speeds();
          any_hit[b] = 1'b1;
        end
        tick();
        any_hit = '0;
        cyc++;
        n_compared++;
        if (xspeed_fric !== exp_bus(1'b0) || yspeed_fric !== exp_bus(1'b1) ||
            stopped !== exp_stop() || fric_state !== 2'(m_state) || done_fric !== (m_state == 2)) begin
          n_mismatched++;
          $display("[TB] FAIL rand shot=%0d cyc=%0d: x=%h y=%h stop=%b st=%0d, required %h/%h/%b/%0d",
                   shot, cyc, xspeed_fric, yspeed_fric, stopped, fric_state,
                   exp_bus(1'b0), exp_bus(1'b1), exp_stop(), m_state);
        end
      end
      n_compared++;
      if (cyc >= 3000) begin
        n_mismatched++;
        $display("[TB] FAIL rand_timeout shot=%0d: cycles=%0d, required < 3000", shot, cyc);
      end
    end
    mode = 1'b0;
    settle_en = 1'b1;
    go_idle();
  endtask

  initial begin
    n_compared = 0; n_mismatched = 0;
    clear = 1'b0; cue_hit = 1'b0; any_hit = '0; mode = 1'b0; settle_en = 1'b1;
    xspeed = '0; yspeed = '0;
    for (int c = 0; c < 2*N; c++) vin[c] = 0;
    test_reset();
    test_clear_idle();
    test_geometric();
    test_linear();
    test_hit();
    test_zero_settle();
    test_saturate();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
